// File: rtl/cpu_types_pkg.sv
// Shared datapath/memory types for the cache bridge: word type, RAM handshake state and bridge FSM state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {IDLE, DREQ, IREQ, RESP, HALTED} bridge_state_t;
endpackage

// File: rtl/bridge_watchdog.sv
// Saturating cycle counter for a pending RAM access; expired flags the last allowed cycle.
module bridge_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != SAT)
      cnt <= cnt + 1'b1;
  end

  // Combinational so the FSM leaves the request state at the end of cycle TIMEOUT.
  assign expired = en && (cnt >= LAST);
endmodule

// File: rtl/cache_bridge.sv
// Single-ported RAM responder replacing the caches; data requests win over fetches.
// Optional CACHE_BRIDGE_ACCESS_COUNT_EN adds saturating icount/dcount hit counters.
module cache_bridge
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      halt,
  input  logic      imemREN,
  input  word_t     imemaddr,
  output word_t     imemload,
  output logic      ihit,
  input  logic      dmemREN,
  input  logic      dmemWEN,
  input  word_t     dmemaddr,
  input  word_t     dmemstore,
  output word_t     dmemload,
  output logic      dhit,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
`ifdef CACHE_BRIDGE_ACCESS_COUNT_EN
  ,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
`endif
);
  bridge_state_t state, nxt;
  word_t lat_addr, lat_store;
  logic  lat_wr, lat_isd, to_flag, halt_pend;
  logic  in_req, expired;

  assign in_req = (state == DREQ) || (state == IREQ);

  bridge_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (!in_req),
    .en      (in_req),
    .expired (expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (halt)                    nxt = HALTED;
        else if (dmemREN || dmemWEN) nxt = DREQ;
        else if (imemREN)            nxt = IREQ;
      end
      DREQ, IREQ: if (ramstate == ACCESS || expired) nxt = RESP;
      RESP:       nxt = (halt || halt_pend) ? HALTED : IDLE;
      HALTED:     nxt = HALTED;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wr    <= 1'b0;
      lat_isd   <= 1'b0;
      to_flag   <= 1'b0;
      halt_pend <= 1'b0;
      imemload  <= '0;
      dmemload  <= '0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          halt_pend <= 1'b0;
          if (!halt) begin
            if (dmemREN || dmemWEN) begin
              lat_addr  <= dmemaddr;
              lat_store <= dmemstore;
              lat_wr    <= dmemWEN;
              lat_isd   <= 1'b1;
              to_flag   <= 1'b0;
            end else if (imemREN) begin
              lat_addr <= imemaddr;
              lat_wr   <= 1'b0;
              lat_isd  <= 1'b0;
              to_flag  <= 1'b0;
            end
          end
        end
        DREQ, IREQ: begin
          // A halt seen mid-transfer must still end in HALTED even if it drops before RESP.
          if (halt) halt_pend <= 1'b1;
          if (ramstate == ACCESS) begin
            if (!lat_wr) begin
              if (lat_isd) dmemload <= ramload;
              else         imemload <= ramload;
            end
          end else if (expired) begin
            err     <= 1'b1;
            to_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset drops them immediately.
  assign ramREN   = (state == IREQ) || (state == DREQ && !lat_wr);
  assign ramWEN   = (state == DREQ) && lat_wr;
  assign ramaddr  = lat_addr;
  assign ramstore = lat_store;
  assign ihit     = (state == RESP) && !lat_isd && !to_flag;
  assign dhit     = (state == RESP) &&  lat_isd && !to_flag;

`ifdef CACHE_BRIDGE_ACCESS_COUNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (ihit && icount != '1) icount <= icount + 1'b1;
      if (dhit && dcount != '1) dcount <= dcount + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_bridge.sv
// Directed bench for cache_bridge with a hit scoreboard; TIMEOUT is set to 8.
module tb_cache_bridge;
  import cpu_types_pkg::*;

  logic      CLK, RST, halt, imemREN, ihit, dmemREN, dmemWEN, dhit;
  logic      ramREN, ramWEN, err;
  word_t     imemaddr, imemload, dmemaddr, dmemstore, dmemload;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
`ifdef CACHE_BRIDGE_ACCESS_COUNT_EN
  logic [31:0] icount, dcount;
`endif

  typedef struct {
    bit    is_d;
    bit    chk;
    word_t data;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  cache_bridge #(.TIMEOUT(8), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
`ifdef CACHE_BRIDGE_ACCESS_COUNT_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input bit is_d, input bit chk, input word_t data);
    exp_t e;
    e.is_d = is_d;
    e.chk  = chk;
    e.data = data;
    q.push_back(e);
  endtask

  // Hold the request state for nwait cycles of waitst, then one ACCESS cycle.
  task automatic do_wait(input int nwait, input ramstate_t waitst, input logic ren,
                         input logic wen, input word_t addr);
    for (int i = 0; i <= nwait; i++) begin
      ramstate = (i == nwait) ? ACCESS : waitst;
      check("req_ren", ramREN, ren);
      check("req_wen", ramWEN, wen);
      check("req_addr", ramaddr, addr);
      tick();
    end
    ramstate = FREE;
  endtask

  // Scoreboard: every hit pulse pops one expected transaction.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ihit && dhit) check("both_hits", 1'b1, 1'b0);
      if (ihit || dhit) begin
        if (q.size() == 0) begin
          check("unexpected_hit", {ihit, dhit}, 2'b00);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("hit_kind", dhit, e.is_d);
          if (e.chk) check("hit_load", dhit ? dmemload : imemload, e.data);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; halt = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = FREE;
    tick(); tick();
    check("rst_ihit", ihit, 1'b0);
    check("rst_dhit", dhit, 1'b0);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_dmemload", dmemload, 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);

    // Fetch with two BUSY cycles before ACCESS.
    RST = 1'b0;
    imemREN = 1'b1; imemaddr = 32'h0000_0040; ramload = 32'h2401_0005; ramstate = BUSY;
    push(1'b0, 1'b1, 32'h2401_0005);
    tick();
    imemREN = 1'b0;
    do_wait(2, BUSY, 1'b1, 1'b0, 32'h40);
    check("t1_ihit", ihit, 1'b1);
    check("t1_ramREN_resp", ramREN, 1'b0);
    check("t1_imemload", imemload, 32'h2401_0005);
    tick();
    check("t1_ihit_low", ihit, 1'b0);

    // Simultaneous write and fetch: write served first.
    dmemWEN = 1'b1; dmemaddr = 32'h80; dmemstore = 32'hDEAD_BEEF;
    imemREN = 1'b1; imemaddr = 32'h44; ramload = 32'hAAAA_0001;
    push(1'b1, 1'b0, '0);
    push(1'b0, 1'b1, 32'hAAAA_0001);
    tick();
    dmemWEN = 1'b0;
    check("t2_ramstore", ramstore, 32'hDEAD_BEEF);
    do_wait(0, BUSY, 1'b0, 1'b1, 32'h80);
    check("t2_dhit", dhit, 1'b1);
    check("t2_ihit_not_yet", ihit, 1'b0);
    tick();
    check("t2_idle_ren", ramREN, 1'b0);
    tick();
    imemREN = 1'b0;
    do_wait(1, BUSY, 1'b1, 1'b0, 32'h44);
    check("t2_ihit", ihit, 1'b1);
    tick();

    // Stuck BUSY read: watchdog fires after 8 cycles, no hit.
    dmemREN = 1'b1; dmemaddr = 32'h200; ramstate = BUSY;
    tick();
    dmemREN = 1'b0;
    repeat (7) tick();
    check("t3_err_early", err, 1'b0);
    check("t3_ren_held", ramREN, 1'b1);
    tick();
    check("t3_err_set", err, 1'b1);
    check("t3_no_dhit", dhit, 1'b0);
    check("t3_dmemload_kept", dmemload, 32'h0);
    tick();
    ramstate = FREE;
    check("t3_idle_ren", ramREN, 1'b0);
    check("t3_err_sticky", err, 1'b1);

    // ERROR responses are retried until ACCESS.
    dmemREN = 1'b1; dmemaddr = 32'h100; ramload = 32'h1234_5678;
    push(1'b1, 1'b1, 32'h1234_5678);
    tick();
    dmemREN = 1'b0;
    do_wait(3, ERROR, 1'b1, 1'b0, 32'h100);
    check("t4_dhit", dhit, 1'b1);
    check("t4_dmemload", dmemload, 32'h1234_5678);
    tick();

    // Halt mid-fetch: fetch completes, then HALTED absorbs requests.
    imemREN = 1'b1; imemaddr = 32'h48; ramload = 32'h0BAD_F00D; ramstate = BUSY;
    push(1'b0, 1'b1, 32'h0BAD_F00D);
    tick();
    tick();
    halt = 1'b1;
    do_wait(1, BUSY, 1'b1, 1'b0, 32'h48);
    check("t5_ihit", ihit, 1'b1);
    tick();
    for (int i = 0; i < 22; i++) begin
      check("t5_halted_strobes", {ramREN, ramWEN, ihit, dhit}, 4'b0000);
      tick();
    end
    imemREN = 1'b0;
`ifdef CACHE_BRIDGE_ACCESS_COUNT_EN
    check("t6_icount", icount, 32'd3);
    check("t6_dcount", dcount, 32'd2);
`endif

    // Reset from HALTED, then reset again in the middle of a read.
    RST = 1'b1; halt = 1'b0;
    tick();
    RST = 1'b0;
    check("t6_after_rst_ren", ramREN, 1'b0);
    dmemREN = 1'b1; dmemaddr = 32'h300; ramstate = BUSY;
    tick();
    dmemREN = 1'b0;
    check("t6_dreq_ren", ramREN, 1'b1);
    tick();
    RST = 1'b1;
    #1;
    check("t6_async_ren_drop", ramREN, 1'b0);
    check("t6_rst_addr", ramaddr, 32'h0);
    check("t6_rst_dhit", dhit, 1'b0);
`ifdef CACHE_BRIDGE_ACCESS_COUNT_EN
    check("t6_icount_rst", icount, 32'd0);
    check("t6_dcount_rst", dcount, 32'd0);
`endif
    tick();
    RST = 1'b0; ramstate = FREE;
    tick(); tick();
    check("sb_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
